// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: NS/EW signal sequencer with all-red clearance and inserted pedestrian walk.
// Optional night flashing-yellow mode is enabled by defining NIGHT_FLASH_EN.
module intersection_phase_scheduler #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
`ifdef NIGHT_FLASH_EN
    input  logic             night,
`endif
    input  logic [CNT_W-1:0] green_len,
    input  logic [CNT_W-1:0] yellow_len,
    input  logic [CNT_W-1:0] allred_len,
    input  logic [CNT_W-1:0] walk_len,
    input  logic             ped_req,
    output logic             ped_ack,
    output logic             ns_red,
    output logic             ns_yellow,
    output logic             ns_green,
    output logic             ew_red,
    output logic             ew_yellow,
    output logic             ew_green,
    output logic             walk,
    output logic [2:0]       phase
);
    localparam logic [2:0] S_NSG = 3'd0;
    localparam logic [2:0] S_NSY = 3'd1;
    localparam logic [2:0] S_AR1 = 3'd2;
    localparam logic [2:0] S_EWG = 3'd3;
    localparam logic [2:0] S_EWY = 3'd4;
    localparam logic [2:0] S_AR2 = 3'd5;
    localparam logic [2:0] S_PED = 3'd6;
    localparam logic [2:0] S_FL  = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d, cur_len, lim, new_len;
    logic             init_q, req_q, req_d, dir_q, dir_d, ack_q, ack_d;
    logic             done, entering, night_w, flash_on;

    always_comb begin
        // The shadow length is not yet valid on the first edge after reset.
        cur_len  = init_q ? allred_len : len_q;
        lim      = (cur_len == '0) ? '0 : cur_len - CNT_W'(1);
        done     = tick && (cnt_q >= lim);
        state_d  = state_q;
        dir_d    = dir_q;
        if (state_q == S_FL) begin
            if (tick && !night_w) state_d = S_AR2;
        end else if (done) begin
            case (state_q)
                S_NSG:   state_d = S_NSY;
                S_NSY:   state_d = S_AR1;
                S_AR1: begin
                    state_d = night_w ? S_FL : req_q ? S_PED : S_EWG;
                    if (!night_w && req_q) dir_d = 1'b1;
                end
                S_EWG:   state_d = S_EWY;
                S_EWY:   state_d = S_AR2;
                S_AR2: begin
                    state_d = night_w ? S_FL : req_q ? S_PED : S_NSG;
                    if (!night_w && req_q) dir_d = 1'b0;
                end
                S_PED:   state_d = dir_q ? S_EWG : S_NSG;
                default: state_d = S_AR2;
            endcase
        end
        entering = state_d != state_q;
        new_len  = (state_d == S_NSG || state_d == S_EWG) ? green_len :
                   (state_d == S_NSY || state_d == S_EWY) ? yellow_len :
                   (state_d == S_PED) ? walk_len : allred_len;
        cnt_d    = entering ? '0 : tick ? cnt_q + CNT_W'(1) : cnt_q;
        len_d    = entering ? new_len : cur_len;
        ack_d    = entering && state_d == S_PED;
        // A request seen during the acknowledge cycle counts as already served.
        req_d    = ack_d ? 1'b0 : (ped_req && !ack_q) ? 1'b1 : req_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_AR2;
            cnt_q   <= '0;
            len_q   <= '0;
            init_q  <= 1'b1;
            req_q   <= 1'b0;
            dir_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            init_q  <= 1'b0;
            req_q   <= req_d;
            dir_q   <= dir_d;
            ack_q   <= ack_d;
        end
    end

`ifdef NIGHT_FLASH_EN
    logic flash_q, flash_d;
    assign night_w  = night;
    assign flash_on = flash_q;
    always_comb flash_d = (state_d != S_FL) ? 1'b0 : (state_q != S_FL) ? 1'b1 : tick ? ~flash_q : flash_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) flash_q <= 1'b0;
        else        flash_q <= flash_d;
    end
`else
    assign night_w  = 1'b0;
    assign flash_on = 1'b0;
`endif

    always_comb begin
        ns_green  = state_q == S_NSG;
        ns_yellow = state_q == S_NSY || (state_q == S_FL && flash_on);
        ns_red    = state_q inside {S_AR1, S_EWG, S_EWY, S_AR2, S_PED};
        ew_green  = state_q == S_EWG;
        ew_yellow = state_q == S_EWY || (state_q == S_FL && flash_on);
        ew_red    = state_q inside {S_NSG, S_NSY, S_AR1, S_AR2, S_PED};
        walk      = state_q == S_PED;
        phase     = state_q;
        ped_ack   = ack_q;
    end
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler: directed-vector self-checking bench for intersection_phase_scheduler.
module tb_intersection_phase_scheduler;
    logic       clk = 1'b0, reset = 1'b0, tick = 1'b0, ped_req = 1'b0;
    logic [7:0] green_len = 8'd3, yellow_len = 8'd1, allred_len = 8'd1, walk_len = 8'd2;
    logic       ped_ack, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
    logic [2:0] phase;
`ifdef NIGHT_FLASH_EN
    logic       night = 1'b0;
`endif
    int checks = 0, failures = 0;

    intersection_phase_scheduler #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .tick(tick),
`ifdef NIGHT_FLASH_EN
        .night(night),
`endif
        .green_len(green_len), .yellow_len(yellow_len), .allred_len(allred_len), .walk_len(walk_len),
        .ped_req(ped_req), .ped_ack(ped_ack),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .walk(walk), .phase(phase)
    );

    always #5 clk = ~clk;

    // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk} for a non-flash phase
    function automatic logic [6:0] exp_lamps(input int ph);
        case (ph)
            0:       return 7'b001_100_0;
            1:       return 7'b010_100_0;
            3:       return 7'b100_001_0;
            4:       return 7'b100_010_0;
            6:       return 7'b100_100_1;
            default: return 7'b100_100_0;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_cycle(input int ph, input logic ak);
        check_eq("phase", 32'(phase), 32'(ph));
        check_eq("ped_ack", 32'(ped_ack), 32'(ak));
        check_eq("lamps", 32'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}), 32'(exp_lamps(ph)));
    endtask

    int ph_tab[39] = '{5,0,0,0,1,2,3,3,3,4, 5,0,0,0,1,2,6,6,3,3, 3,4,5,0,0,0,1,2,6,6, 3,3,3,4,5,6,6,0,0};

    initial begin
        // Normal cycle, pedestrian insertion, ack-cycle request, held request
        tick = 1'b1;
        repeat (3) @(negedge clk);
        check_cycle(5, 1'b0);
        reset = 1'b1;
        for (int c = 0; c < 39; c++) begin
            check_cycle(ph_tab[c], c == 16 || c == 28 || c == 35);
            ped_req = (c == 11 || c == 16 || c == 23 || c == 28 || c == 29);
            @(negedge clk);
        end
        ped_req = 1'b0;
        // Sparse ticks, zero green length, mid-phase length change
        reset = 1'b0;
        tick = 1'b0;
        green_len = 8'd0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 37; c++) begin
            check_cycle(c < 4 ? 5 : c < 8 ? 0 : c < 12 ? 1 : c < 16 ? 2 : c < 36 ? 3 : 4, 1'b0);
            tick = (c % 4 == 3);
            if (c == 5) green_len = 8'd5;
            @(negedge clk);
        end
        // Asynchronous reset in the middle of EW_GREEN
        reset = 1'b0;
        tick = 1'b1;
        green_len = 8'd3;
        @(negedge clk);
        reset = 1'b1;
        repeat (7) @(negedge clk);
        check_eq("pre_reset_phase", 32'(phase), 32'd3);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("async_phase", 32'(phase), 32'd5);
        check_eq("async_lamps", 32'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}), 32'(7'b100_100_0));
        check_eq("async_ack", 32'(ped_ack), 32'd0);
        allred_len = 8'd3;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check_cycle(c < 3 ? 5 : 0, 1'b0);
            @(negedge clk);
        end
`ifdef NIGHT_FLASH_EN
        // Night flash entry after ALL_RED_1, then recovery through ALL_RED_2
        reset = 1'b0;
        allred_len = 8'd1;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c >= 6 && c <= 8) begin
                check_eq("flash_phase", 32'(phase), 32'd7);
                check_eq("flash_ns_y", 32'(ns_yellow), 32'(c != 7));
                check_eq("flash_ew_y", 32'(ew_yellow), 32'(c != 7));
                check_eq("flash_others", 32'({ns_red, ns_green, ew_red, ew_green, walk}), 32'd0);
            end else begin
                check_cycle(c == 0 ? 5 : c < 4 ? 0 : c == 4 ? 1 : c == 5 ? 2 : c == 9 ? 5 : 0, 1'b0);
            end
            night = (c >= 1 && c < 8);
            @(negedge clk);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
